// File: rtl/prio_encoder_reg_if.sv
// Handshake and result bundle for prio_encoder_reg: request side, result side
// and the error-counter controls. The master drives requests; the encoder is the slave.
interface prio_encoder_reg_if #(
   parameter int N     = 8,
   parameter int CNT_W = 8
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic             in_vld;
   logic             in_rdy;
   logic [N-1:0]     req;
   logic             out_vld;
   logic             out_rdy;
   logic [IW-1:0]    idx;
   logic             any;
   logic             multi;
   logic             err_clr;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output in_vld, req, out_rdy, err_clr,
      input  in_rdy, out_vld, idx, any, multi, err_cnt
   );

   modport slave (
      input  in_vld, req, out_rdy, err_clr,
      output in_rdy, out_vld, idx, any, multi, err_cnt
   );
endinterface

// File: rtl/prio_encoder_reg.sv
// Registered priority encoder behind a one-entry, bubble-free output buffer,
// with a saturating counter of accepted vectors that were not exactly one-hot.
module prio_encoder_reg #(
   parameter int N         = 8,
   parameter int MSB_FIRST = 0,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   prio_encoder_reg_if.slave  bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic             out_vld_q;
   logic [IW-1:0]    idx_q;
   logic             any_q;
   logic             multi_q;
   logic [CNT_W-1:0] err_q;

   logic             accept;
   logic [IW-1:0]    enc_idx;
   logic             enc_any;
   logic             enc_multi;

   assign bus.in_rdy = !out_vld_q || bus.out_rdy;
   assign accept     = bus.in_vld && bus.in_rdy;

   // The scan direction is chosen so the last hit written is the winner.
   always_comb begin
      enc_idx   = '0;
      enc_any   = |bus.req;
      enc_multi = (bus.req & (bus.req - N'(1))) != '0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
               enc_idx = IW'(i);
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
               enc_idx = IW'(i);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q <= 1'b0;
         idx_q     <= '0;
         any_q     <= 1'b0;
         multi_q   <= 1'b0;
      end else if (accept) begin
         out_vld_q <= 1'b1;
         idx_q     <= enc_idx;
         any_q     <= enc_any;
         multi_q   <= enc_multi;
      end else if (bus.out_rdy) begin
         out_vld_q <= 1'b0;
      end
   end

   // An empty vector counts as an error just like a multi-hot one.
   always_ff @(posedge clk) begin
      if (rst || bus.err_clr) begin
         err_q <= '0;
      end else if (accept && (enc_multi || !enc_any) && (err_q != '1)) begin
         err_q <= err_q + CNT_W'(1);
      end
   end

   assign bus.out_vld = out_vld_q;
   assign bus.idx     = idx_q;
   assign bus.any     = any_q;
   assign bus.multi   = multi_q;
   assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_prio_encoder_reg.sv
// Drives three encoder configurations (LSB-first, MSB-first, 2-bit counter) in
// lockstep and compares every cycle against a popcount/log2 reference model.
module tb_prio_encoder_reg;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_vld;
   logic [7:0] req;
   logic       out_rdy;
   logic       err_clr;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   prio_encoder_reg_if #(.N(8), .CNT_W(8)) if0 ();
   prio_encoder_reg_if #(.N(8), .CNT_W(8)) if1 ();
   prio_encoder_reg_if #(.N(8), .CNT_W(2)) if2 ();

   assign if0.in_vld = in_vld;  assign if0.req = req;  assign if0.out_rdy = out_rdy;  assign if0.err_clr = err_clr;
   assign if1.in_vld = in_vld;  assign if1.req = req;  assign if1.out_rdy = out_rdy;  assign if1.err_clr = err_clr;
   assign if2.in_vld = in_vld;  assign if2.req = req;  assign if2.out_rdy = out_rdy;  assign if2.err_clr = err_clr;

   prio_encoder_reg #(.N(8), .MSB_FIRST(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   prio_encoder_reg #(.N(8), .MSB_FIRST(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   prio_encoder_reg #(.N(8), .MSB_FIRST(0), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   logic       o_rdy   [3];
   logic       o_vld   [3];
   logic       o_any   [3];
   logic       o_multi [3];
   logic [2:0] o_idx   [3];
   logic [7:0] o_err   [3];

   assign o_rdy[0] = if0.in_rdy;  assign o_vld[0] = if0.out_vld;  assign o_any[0] = if0.any;
   assign o_rdy[1] = if1.in_rdy;  assign o_vld[1] = if1.out_vld;  assign o_any[1] = if1.any;
   assign o_rdy[2] = if2.in_rdy;  assign o_vld[2] = if2.out_vld;  assign o_any[2] = if2.any;
   assign o_multi[0] = if0.multi; assign o_idx[0] = if0.idx;      assign o_err[0] = if0.err_cnt;
   assign o_multi[1] = if1.multi; assign o_idx[1] = if1.idx;      assign o_err[1] = if1.err_cnt;
   assign o_multi[2] = if2.multi; assign o_idx[2] = if2.idx;      assign o_err[2] = {6'b0, if2.err_cnt};

   // Reference model state, one slot per configuration.
   bit msb_cfg [3] = '{1'b0, 1'b1, 1'b0};
   int err_max [3] = '{255, 255, 3};
   bit m_vld;
   bit m_any;
   bit m_multi;
   int m_idx [3];
   int m_err [3];

   function automatic int lsb_pos(input int unsigned v);
      if (v == 0) return 0;
      return $clog2(v & (~v + 1));
   endfunction

   function automatic int msb_pos(input int unsigned v);
      if (v == 0) return 0;
      return $clog2(v + 1) - 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Called just after a falling edge: drive, check in_rdy, advance model, check outputs.
   task automatic applyStimulus(input bit v, input logic [7:0] r, input bit ordy,
                                input bit clr, input bit rs);
      bit acc;
      int pop;
      in_vld  = v;
      req     = r;
      out_rdy = ordy;
      err_clr = clr;
      rst     = rs;
      #1;
      for (int c = 0; c < 3; c++)
         checkOutput($sformatf("dut%0d.in_rdy", c), 64'(o_rdy[c]), 64'(!m_vld || ordy));
      acc = v && (!m_vld || ordy);
      pop = $countones(r);
      if (rs) begin
         m_vld   = 1'b0;
         m_any   = 1'b0;
         m_multi = 1'b0;
         for (int c = 0; c < 3; c++) begin
            m_idx[c] = 0;
            m_err[c] = 0;
         end
      end else begin
         if (acc) begin
            m_vld   = 1'b1;
            m_any   = (pop != 0);
            m_multi = (pop >= 2);
            for (int c = 0; c < 3; c++)
               m_idx[c] = msb_cfg[c] ? msb_pos(32'(r)) : lsb_pos(32'(r));
         end else if (ordy) begin
            m_vld = 1'b0;
         end
         for (int c = 0; c < 3; c++) begin
            if (clr) m_err[c] = 0;
            else if (acc && pop != 1 && m_err[c] < err_max[c]) m_err[c]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         checkOutput($sformatf("dut%0d.out_vld", c), 64'(o_vld[c]), 64'(m_vld));
         checkOutput($sformatf("dut%0d.idx", c), 64'(o_idx[c]), 64'(m_idx[c]));
         checkOutput($sformatf("dut%0d.any", c), 64'(o_any[c]), 64'(m_any));
         checkOutput($sformatf("dut%0d.multi", c), 64'(o_multi[c]), 64'(m_multi));
         checkOutput($sformatf("dut%0d.err_cnt", c), 64'(o_err[c]), 64'(m_err[c]));
      end
   endtask

   initial begin
      logic [7:0] r;
      m_vld = 1'b0; m_any = 1'b0; m_multi = 1'b0;
      for (int c = 0; c < 3; c++) begin
         m_idx[c] = 0;
         m_err[c] = 0;
      end

      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
      checkOutput("reset.out_vld", 64'(o_vld[0]), 64'd0);

      // Back-to-back one-hot vectors with the sink always ready.
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b1, 1'b0, 1'b0);
      checkOutput("onehot.idx7", 64'(o_idx[0]), 64'd7);

      applyStimulus(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
      checkOutput("lsb.idx_0A", 64'(o_idx[0]), 64'd1);
      checkOutput("msb.idx_0A", 64'(o_idx[1]), 64'd3);
      checkOutput("lsb.err_0A", 64'(o_err[0]), 64'd1);
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("zero.any", 64'(o_any[0]), 64'd0);
      checkOutput("zero.err", 64'(o_err[0]), 64'd2);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Stall with a new vector waiting, then drain and replace in one edge.
      applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      checkOutput("stall.idx", 64'(o_idx[0]), 64'd4);
      applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 1'b0);
      checkOutput("replace.idx", 64'(o_idx[0]), 64'd5);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Counter saturation on the 2-bit instance, then clear beating an increment.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
         applyStimulus(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
      checkOutput("sat.err", 64'(o_err[2]), 64'd3);
      applyStimulus(1'b1, 8'h0C, 1'b1, 1'b1, 1'b0);
      checkOutput("clr.err", 64'(o_err[2]), 64'd0);

      // Reset while a result is stalled drops it and the presented vector.
      applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checkOutput("rstdrop.vld", 64'(o_vld[0]), 64'd0);

      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0:       r = 8'h00;
            1:       r = 8'(1 << $urandom_range(0, 7));
            default: r = 8'($urandom);
         endcase
         applyStimulus(1'($urandom_range(0, 3) != 0), r, 1'($urandom_range(0, 2) != 0),
                       1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
